// File: rtl/cache_sa.sv
// Set-associative (1- or 2-way) cache storage array with per-set LRU, victim selection and an invalidate-all flush sequencer.
// Optional hit/miss statistics counters are enabled by defining CACHE_SA_STATS_EN.
module cache_sa #(
    parameter  int TAG_W   = 5,
    parameter  int INDEX_W = 8,
    parameter  int WORDS   = 4,
    parameter  int DATA_W  = 16,
    parameter  int WAYS    = 2,
    localparam int OFF_W   = $clog2(WORDS) + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic               comp,
    input  logic               write,
    input  logic               valid_in,
    input  logic [TAG_W-1:0]   tag_in,
    input  logic [INDEX_W-1:0] index,
    input  logic [OFF_W-1:0]   offset,
    input  logic [DATA_W-1:0]  data_in,
    input  logic               way_in,
    input  logic               flush_req,
    output logic [TAG_W-1:0]   tag_out,
    output logic [DATA_W-1:0]  data_out,
    output logic               hit,
    output logic               dirty,
    output logic               valid,
    output logic               way_out,
    output logic               victim,
    output logic               err,
    output logic               flush_busy,
    output logic [15:0]        hit_cnt,
    output logic [15:0]        miss_cnt
);

    localparam int SETS = 1 << INDEX_W;

    typedef enum logic {IDLE, FLUSH} state_t;

    state_t state, state_nx;
    logic [INDEX_W-1:0] cnt;

    // Way 1 storage is always declared; with WAYS == 1 it is never written or selected.
    logic [TAG_W-1:0]  tag_mem  [2][SETS];
    logic [DATA_W-1:0] data_mem [2][SETS][WORDS];
    logic [SETS-1:0]   valid_r  [2];
    logic [SETS-1:0]   dirty_r  [2];
    logic [SETS-1:0]   lru_r;

    logic [1:0]       match;
    logic             any_match, hit_way, victim_w, sel_way;
    logic             go, err_w, upd, cmp_hit, do_wr, do_lru, flush_start;
    logic [OFF_W-2:0] word;

    assign go          = enable & ~flush_busy;
    assign err_w       = enable & offset[0];
    assign upd         = go & ~err_w;
    assign word        = offset[OFF_W-1:1];
    assign flush_busy  = (state == FLUSH);
    assign flush_start = (state == IDLE) & flush_req;

    always_comb begin
        match[0] = valid_r[0][index] & (tag_mem[0][index] == tag_in);
        match[1] = (WAYS == 2) & valid_r[1][index] & (tag_mem[1][index] == tag_in);
        any_match = |match;
        hit_way   = ~match[0];
        if (WAYS == 1)
            victim_w = 1'b0;
        else if (!valid_r[0][index])
            victim_w = 1'b0;
        else if (!valid_r[1][index])
            victim_w = 1'b1;
        else
            victim_w = lru_r[index];
        if (comp)
            sel_way = any_match ? hit_way : victim_w;
        else
            sel_way = (WAYS == 2) ? way_in : 1'b0;
    end

    assign cmp_hit = go & comp & any_match;
    assign do_wr   = upd & write & (~comp | any_match);
    assign do_lru  = upd & (comp ? any_match : write);

    always_comb begin
        tag_out  = '0;
        data_out = '0;
        hit      = 1'b0;
        dirty    = 1'b0;
        valid    = 1'b0;
        way_out  = 1'b0;
        if (go) begin
            tag_out = tag_mem[sel_way][index];
            dirty   = dirty_r[sel_way][index];
            valid   = valid_r[sel_way][index];
            way_out = sel_way;
            hit     = cmp_hit;
            if (!write)
                data_out = data_mem[sel_way][index][word];
        end
    end

    assign victim = victim_w;
    assign err    = err_w;

    always_ff @(posedge clk) begin
        if (do_wr) begin
            data_mem[sel_way][index][word] <= data_in;
            if (!comp)
                tag_mem[sel_way][index] <= tag_in;
        end
    end

    // Accesses are blocked while flushing, so flush clears never collide with access updates.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned w = 0; w < 2; w++) begin
                valid_r[w] <= '0;
                dirty_r[w] <= '0;
            end
            lru_r <= '0;
        end else if (state == FLUSH) begin
            for (int unsigned w = 0; w < 2; w++) begin
                valid_r[w][cnt] <= 1'b0;
                dirty_r[w][cnt] <= 1'b0;
            end
            lru_r[cnt] <= 1'b0;
        end else begin
            if (do_wr) begin
                if (comp) begin
                    dirty_r[sel_way][index] <= 1'b1;
                end else begin
                    valid_r[sel_way][index] <= valid_in;
                    dirty_r[sel_way][index] <= 1'b0;
                end
            end
            if (do_lru)
                lru_r[index] <= ~sel_way;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE)
                cnt <= '0;
            else
                cnt <= cnt + 1'b1;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (flush_req) state_nx = FLUSH;
            FLUSH:   if (cnt == '1) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

`ifdef CACHE_SA_STATS_EN
    logic [15:0] hit_q, miss_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hit_q  <= '0;
            miss_q <= '0;
        end else if (flush_start) begin
            hit_q  <= '0;
            miss_q <= '0;
        end else if (go && comp && !err_w) begin
            if (cmp_hit) begin
                if (hit_q != '1)
                    hit_q <= hit_q + 1'b1;
            end else begin
                if (miss_q != '1)
                    miss_q <= miss_q + 1'b1;
            end
        end
    end

    assign hit_cnt  = hit_q;
    assign miss_cnt = miss_q;
`else
    assign hit_cnt  = '0;
    assign miss_cnt = '0;
`endif

endmodule

// File: tb/tb_cache_sa.sv
// Randomized self-checking bench for cache_sa against a per-set/per-way behavioural model.
module tb_cache_sa;

    localparam int TAG_W   = 5;
    localparam int INDEX_W = 8;
    localparam int WORDS   = 4;
    localparam int DATA_W  = 16;
    localparam int WAYS    = 2;
    localparam int OFF_W   = 3;
    localparam int SETS    = 256;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               enable = 1'b0, comp = 1'b0, write = 1'b0, valid_in = 1'b0;
    logic [TAG_W-1:0]   tag_in = '0;
    logic [INDEX_W-1:0] index = '0;
    logic [OFF_W-1:0]   offset = '0;
    logic [DATA_W-1:0]  data_in = '0;
    logic               way_in = 1'b0, flush_req = 1'b0;
    logic [TAG_W-1:0]   tag_out;
    logic [DATA_W-1:0]  data_out;
    logic               hit, dirty, valid, way_out, victim, err, flush_busy;
    logic [15:0]        hit_cnt, miss_cnt;

    int n_checks = 0;
    int n_errors = 0;

    cache_sa #(
        .TAG_W(TAG_W), .INDEX_W(INDEX_W), .WORDS(WORDS), .DATA_W(DATA_W), .WAYS(WAYS)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .comp(comp), .write(write),
        .valid_in(valid_in), .tag_in(tag_in), .index(index), .offset(offset),
        .data_in(data_in), .way_in(way_in), .flush_req(flush_req),
        .tag_out(tag_out), .data_out(data_out), .hit(hit), .dirty(dirty),
        .valid(valid), .way_out(way_out), .victim(victim), .err(err),
        .flush_busy(flush_busy), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: one record per (way, set), LRU names the way to evict next.
    logic [TAG_W-1:0]  m_tag  [2][SETS];
    bit                m_tag_ok [2][SETS];
    logic [DATA_W-1:0] m_data [2][SETS][WORDS];
    bit                m_data_ok [2][SETS][WORDS];
    bit                m_valid [2][SETS];
    bit                m_dirty [2][SETS];
    bit                m_lru [SETS];
    int                m_fb = 0;
    int                m_hits = 0, m_miss = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int m_victim(input int idx);
        if (!m_valid[0][idx]) return 0;
        if (!m_valid[1][idx]) return 1;
        return int'(m_lru[idx]);
    endfunction

    function automatic void m_clear_state();
        for (int s = 0; s < SETS; s++) begin
            m_valid[0][s] = 0; m_valid[1][s] = 0;
            m_dirty[0][s] = 0; m_dirty[1][s] = 0;
            m_lru[s] = 0;
        end
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0; enable = 1'b0; flush_req = 1'b0; index = 8'h05;
        #1;
        check("rst_busy", flush_busy, 0);
        check("rst_victim", victim, 0);
        m_clear_state();
        m_fb = 0; m_hits = 0; m_miss = 0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    // One clock cycle: drive, check combinational outputs against the model, advance the model.
    task automatic op(input bit en, input bit cmp, input bit wr, input bit vin, input int tg,
                      input int idx, input int off, input int dat, input bit wy, input bit fl);
        bit go, e, h;
        int hw, sel, wi;
        @(negedge clk);
        enable = en; comp = cmp; write = wr; valid_in = vin;
        tag_in = tg[TAG_W-1:0]; index = idx[INDEX_W-1:0]; offset = off[OFF_W-1:0];
        data_in = dat[DATA_W-1:0]; way_in = wy; flush_req = fl;
        #1;
        go = en && (m_fb == 0);
        e  = en && (off % 2 == 1);
        wi = (off % 8) / 2;
        hw = -1;
        for (int w = 1; w >= 0; w--)
            if (m_valid[w][idx] && m_tag[w][idx] == tg[TAG_W-1:0]) hw = w;
        sel = cmp ? ((hw >= 0) ? hw : m_victim(idx)) : int'(wy);
        h = go && cmp && (hw >= 0);

        check("hit", hit, h);
        check("err", err, e);
        check("flush_busy", flush_busy, m_fb != 0);
        if (m_fb == 0) check("victim", victim, m_victim(idx));
        check("way_out", way_out, go ? sel : 0);
        check("valid", valid, go ? m_valid[sel][idx] : 0);
        check("dirty", dirty, go ? m_dirty[sel][idx] : 0);
        if (!go) check("tag_out", tag_out, 0);
        else if (m_tag_ok[sel][idx]) check("tag_out", tag_out, m_tag[sel][idx]);
        if (wr || !go) check("data_out", data_out, 0);
        else if (m_data_ok[sel][idx][wi]) check("data_out", data_out, m_data[sel][idx][wi]);
`ifdef CACHE_SA_STATS_EN
        check("hit_cnt", hit_cnt, m_hits);
        check("miss_cnt", miss_cnt, m_miss);
`else
        check("hit_cnt", hit_cnt, 0);
        check("miss_cnt", miss_cnt, 0);
`endif

        if (go && !e) begin
            if (cmp) begin
                if (hw >= 0) begin
                    m_lru[idx] = (hw == 0);
                    if (wr) begin
                        m_data[hw][idx][wi] = dat[DATA_W-1:0];
                        m_data_ok[hw][idx][wi] = 1;
                        m_dirty[hw][idx] = 1;
                    end
                end
                if (h) m_hits = (m_hits < 65535) ? m_hits + 1 : m_hits;
                else   m_miss = (m_miss < 65535) ? m_miss + 1 : m_miss;
            end else if (wr) begin
                m_data[sel][idx][wi] = dat[DATA_W-1:0];
                m_data_ok[sel][idx][wi] = 1;
                m_tag[sel][idx] = tg[TAG_W-1:0];
                m_tag_ok[sel][idx] = 1;
                m_valid[sel][idx] = vin;
                m_dirty[sel][idx] = 0;
                m_lru[idx] = (sel == 0);
            end
        end
        if (m_fb > 0) m_fb--;
        else if (fl) begin
            m_fb = SETS;
            m_clear_state();
            m_hits = 0; m_miss = 0;
        end
    endtask

    initial begin
        int busy_cycles;
        int wdata [4];
        wdata = '{32'h1111, 32'h2222, 32'h3333, 32'h4444};

        do_reset();
        op(1, 1, 0, 0, 'h1A, 'h05, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) op(1, 0, 1, 1, 'h1A, 'h05, i * 2, wdata[i], 0, 0);
        op(1, 1, 0, 0, 'h1A, 'h05, 4, 0, 0, 0);
        for (int i = 0; i < 4; i++) op(1, 0, 1, 1, 'h0C, 'h05, i * 2, 'hA000 + i, 1, 0);
        op(1, 1, 0, 0, 'h1A, 'h05, 0, 0, 0, 0);
        op(0, 0, 0, 0, 'h00, 'h05, 0, 0, 0, 0);
        check("victim_after_hit0", victim, 1);
        op(1, 1, 1, 0, 'h0C, 'h05, 2, 'hBEEF, 0, 0);
        op(1, 1, 0, 0, 'h0C, 'h05, 2, 0, 0, 0);
        check("bEEF_readback", data_out, 16'hBEEF);
        check("dirty_way1", dirty, 1);
        check("victim_after_hit1", victim, 0);
        op(1, 1, 1, 0, 'h1A, 'h05, 3, 'hDEAD, 0, 0);
        op(1, 1, 0, 0, 'h1A, 'h05, 2, 0, 0, 0);
        check("err_no_write", data_out, 16'h2222);

        // Flush with a concurrent access; a second request while busy is ignored.
        op(1, 1, 0, 0, 'h1A, 'h05, 0, 0, 0, 1);
        busy_cycles = 0;
        for (int k = 0; k < 300; k++) begin
            op(1, 1, 0, 0, 'h1A, 'h05, 0, 0, 0, k == 10);
            if (flush_busy === 1'b1) busy_cycles++;
            else break;
        end
        check("flush_len", busy_cycles, 256);
        check("post_flush_hit", hit, 0);
        check("post_flush_valid", valid, 0);

        // Reset mid-flush aborts the sequence.
        op(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        for (int k = 0; k < 5; k++) op(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        do_reset();
        op(1, 1, 0, 0, 'h0C, 'h05, 0, 0, 0, 0);

`ifdef CACHE_SA_STATS_EN
        do_reset();
        op(1, 0, 1, 1, 'h1A, 'h05, 0, 'h1234, 0, 0);
        for (int i = 0; i < 3; i++) op(1, 1, 0, 0, 'h1A, 'h05, 0, 0, 0, 0);
        for (int i = 0; i < 2; i++) op(1, 1, 0, 0, 'h03, 'h05, 0, 0, 0, 0);
        op(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        check("stats_hit3", hit_cnt, 3);
        check("stats_miss2", miss_cnt, 2);
        for (int i = 0; i < 65540; i++) op(1, 1, 0, 0, 'h1A, 'h05, 0, 0, 0, 0);
        op(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        check("stats_sat", hit_cnt, 16'hFFFF);
`endif

        for (int n = 0; n < 4000; n++) begin
            int ix, off;
            ix  = $urandom_range(0, 3);
            ix  = (ix == 3) ? 255 : ix;
            off = $urandom_range(0, 7);
            if ($urandom_range(0, 7) != 0) off = off & 6;
            op($urandom_range(0, 9) != 0, $urandom_range(0, 1), $urandom_range(0, 1),
               $urandom_range(0, 4) != 0, $urandom_range(0, 3), ix, off,
               $urandom_range(0, 65535), $urandom_range(0, 1), $urandom_range(0, 399) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/cache_sa.md
Name: cache_sa

Overview:
- Parametrised N-word-line cache storage array, successor to the direct-mapped single-size array.
- Configurable tag, index, line and data widths; 1- or 2-way set-associative.
- Per-set LRU and victim selection; hit qualified by valid; misaligned writes blocked; multi-cycle invalidate-all flush sequencer.
- Sits under the memory-system controller FSM, which keeps the same comp/write/valid_in access protocol.

Parameters:
- TAG_W, 5, tag width in bits.
- INDEX_W, 8, set index width; 2^INDEX_W sets.
- WORDS, 4, words per line, power of 2 (≥2).
- DATA_W, 16, word width.
- WAYS, 2, associativity; only 1 or 2 legal.
- OFF_W = log2(WORDS)+1 (derived, not overridable): byte offset width; bit 0 is the byte bit.

Ports:
- clk  in  1  clock; all writes on rising edge.
- rst  in  1  asynchronous, active-low reset (asserted at 0).
- enable  in  1  access strobe.
- comp  in  1  1 = compare mode, 0 = access mode.
- write  in  1  1 = write, 0 = read.
- valid_in  in  1  valid bit written on access-write.
- tag_in  in  TAG_W  tag for compare / access-write.
- index  in  INDEX_W  set select.
- offset  in  OFF_W  byte offset in line.
- data_in  in  DATA_W  write data.
- way_in  in  1  target way in access mode (ignored when WAYS=1).
- flush_req  in  1  one-cycle pulse: invalidate whole cache.
- tag_out  out  TAG_W  tag of selected way.
- data_out  out  DATA_W  read word of selected way.
- hit  out  1  compare hit.
- dirty  out  1  dirty bit of selected way.
- valid  out  1  valid bit of selected way.
- way_out  out  1  selected way.
- victim  out  1  replacement way for index.
- err  out  1  misaligned access.
- flush_busy  out  1  flush in progress.

Behaviour:
- Storage: flop arrays with combinational read and synchronous write. rst clears valid, dirty and LRU for every set and forces FSM to IDLE; tag/data arrays are not reset.
- go = enable & ~flush_busy. err = enable & offset[0]. An err access performs no array write.
- Per-way match_w = valid_w & (tag_w == tag_in).
- Victim: lowest-numbered invalid way, else LRU way. WAYS=1 → victim = 0.
- Selected way:
  - comp=1: hit way when matched, else victim.
  - comp=0: way_in.
  - way_out reports the selected way.
- Compare read: hit = go & |match; outputs reflect the selected way. On hit, LRU ← other way.
- Compare write:
  - Hit: word[offset[OFF_W-1:1]] ← data_in, dirty ← 1, LRU updated.
  - Miss: no write; tag_out/dirty/valid show the victim for writeback decision.
- Access read: outputs show way_in; hit = 0; no state change.
- Access write: word ← data_in, tag ← tag_in, valid ← valid_in, dirty ← 0, LRU ← other way; hit = 0.
- Output gating: data_out = 0 when write | ~go. tag_out, dirty, valid, hit and way_out are 0 when ~go.
- Flush FSM, IDLE / FLUSH:
  - IDLE → FLUSH on flush_req; set counter ← 0.
  - In FLUSH, each cycle clears valid/dirty/LRU of set[cnt] and increments cnt.
  - FLUSH → IDLE after set 2^INDEX_W−1; exactly 2^INDEX_W busy cycles. flush_busy = (state == FLUSH).
  - flush_req while busy is ignored.
  - flush_req with a concurrent access in IDLE: the access completes that cycle; the flush starts next cycle.
  - rst mid-flush aborts to IDLE.
- Same-set read-after-write: the new value is visible on the cycle after the write edge.

Optional Feature:
- Macro CACHE_SA_STATS_EN.
- When defined, adds outputs hit_cnt[15:0] and miss_cnt[15:0]:
  - Saturating counters.
  - Increment on each go & comp & ~err cycle, by hit / ~hit.
  - Cleared by rst and at flush start.
- When undefined, both ports exist and are tied to 0; no counter flops are built.

Test Plan:
- Reset, then compare-read index 0x05, tag 0x1A, WAYS=2 → hit=0, valid=0, victim=0, way_out=0.
- Access-write way 0 at index 0x05, tag 0x1A, offsets 0,2,4,6, data 0x1111/2222/3333/4444, valid_in=1; then compare-read offset 4 → hit=1, data_out=0x3333, way_out=0, dirty=0, victim=1.
- Fill way 1 at index 0x05 with tag 0x0C; compare-read tag 0x1A (hit way 0) → victim=1. Compare-write tag 0x0C offset 2 data 0xBEEF → dirty=1 on way 1, victim=0.
- Compare-write offset 3 on a hitting line → err=1, no data change: re-read returns the old word.
- Pulse flush_req → flush_busy high for exactly 256 cycles, accesses return zeros; afterwards compare-read tag 0x1A → hit=0, valid=0.
- With CACHE_SA_STATS_EN: 3 compare hits and 2 misses → hit_cnt=3, miss_cnt=2. Force 65540 hits → hit_cnt=0xFFFF.
